// File: rtl/regfile_ctx.sv
// regfile_ctx: parametrised register file with index register IX (reg NREG-1),
// two combinational read ports, a constant generator, single-cycle swap,
// IX increment/decrement and a shadow context bank copied one register per
// cycle by a save/restore sequencer.
// Optional build macro REGFILE_CTX_DIRECT_OUT_EN adds the ALLREGS debug port.
module regfile_ctx #(
  parameter int WIDTH = 8,
  parameter int NREG  = 4,
  localparam int AW   = $clog2(NREG)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] IN,
  input  logic             WE,
  input  logic [AW-1:0]    WA,
  input  logic [AW-1:0]    RAA,
  input  logic [AW-1:0]    RAB,
  input  logic             CSEL,
  input  logic             SWAP,
  input  logic             IXINC,
  input  logic             IXDEC,
  input  logic             SAVE,
  input  logic             RESTORE,
  output logic [WIDTH-1:0] OUTA,
  output logic [WIDTH-1:0] OUTB,
  output logic [WIDTH-1:0] OUTC,
  output logic             BUSY,
  output logic             DONE
`ifdef REGFILE_CTX_DIRECT_OUT_EN
  ,
  output logic [WIDTH*NREG-1:0] ALLREGS
`endif
);

  localparam int            IX       = NREG - 1;
  localparam logic [AW-1:0] CNT_LAST = AW'(NREG - 1);
  localparam logic [AW-1:0] CNT_ONE  = AW'(32'd1);
  localparam logic [WIDTH-1:0] IX_ONE = WIDTH'(32'd1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SAVING    = 2'd1,
    ST_RESTORING = 2'd2
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [AW-1:0]    cnt_r, cnt_nxt_s;
  logic             done_r, done_nxt_s;
  logic [WIDTH-1:0] regs_r   [NREG];
  logic [WIDTH-1:0] regs_nxt_s [NREG];
  logic [WIDTH-1:0] shadow_r [NREG];
  logic [WIDTH-1:0] shadow_nxt_s [NREG];

  // Next-state and next register contents; IDLE requests are strictly prioritised,
  // so only one action ever takes effect per edge.
  always_comb begin
    state_nxt_s  = state_r;
    cnt_nxt_s    = cnt_r;
    done_nxt_s   = 1'b0;
    regs_nxt_s   = regs_r;
    shadow_nxt_s = shadow_r;
    case (state_r)
      ST_IDLE: begin
        if (SAVE) begin
          state_nxt_s = ST_SAVING;
          cnt_nxt_s   = {AW{1'b0}};
        end else if (RESTORE) begin
          state_nxt_s = ST_RESTORING;
          cnt_nxt_s   = {AW{1'b0}};
        end else if (SWAP) begin
          regs_nxt_s[RAA] = regs_r[RAB];
          regs_nxt_s[RAB] = regs_r[RAA];
        end else if (WE) begin
          regs_nxt_s[WA] = IN;
        end else if (IXINC && !IXDEC) begin
          regs_nxt_s[IX] = regs_r[IX] + IX_ONE;
        end else if (IXDEC && !IXINC) begin
          regs_nxt_s[IX] = regs_r[IX] - IX_ONE;
        end else begin
          regs_nxt_s = regs_r;
        end
      end
      ST_SAVING, ST_RESTORING: begin
        if (state_r == ST_SAVING) begin
          shadow_nxt_s[cnt_r] = regs_r[cnt_r];
        end else begin
          regs_nxt_s[cnt_r] = shadow_r[cnt_r];
        end
        if (cnt_r == CNT_LAST) begin
          state_nxt_s = ST_IDLE;
          done_nxt_s  = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = {AW{1'b0}};
      end
    endcase
  end

  // State, counter, DONE pulse and both register banks; reset aborts any sequence.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r <= ST_IDLE;
      cnt_r   <= {AW{1'b0}};
      done_r  <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        regs_r[i]   <= {WIDTH{1'b0}};
        shadow_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      state_r  <= state_nxt_s;
      cnt_r    <= cnt_nxt_s;
      done_r   <= done_nxt_s;
      regs_r   <= regs_nxt_s;
      shadow_r <= shadow_nxt_s;
    end
  end

  // Read ports and constant generator stay live in every state.
  always_comb begin
    OUTA = regs_r[RAA];
    OUTB = regs_r[RAB];
    OUTC = {WIDTH{CSEL}};
    BUSY = (state_r != ST_IDLE);
    DONE = done_r;
  end

`ifdef REGFILE_CTX_DIRECT_OUT_EN
  // Flattened view of the live bank for debug display.
  always_comb begin
    ALLREGS = {(WIDTH*NREG){1'b0}};
    for (int i = 0; i < NREG; i++) begin
      ALLREGS[i*WIDTH +: WIDTH] = regs_r[i];
    end
  end
`endif

endmodule

// File: tb/tb_regfile_ctx.sv
// Self-checking bench for regfile_ctx: an 8-bit/4-register instance and a
// 16-bit/8-register instance. A reference model of the live and shadow banks
// feeds an expected-value queue that is drained against the read ports.
module tb_regfile_ctx;

  logic       clk;
  logic       rst;
  logic [7:0] in8;
  logic       we, csel, swap, ixinc, ixdec, save, restore;
  logic [1:0] wa, raa, rab;
  logic [7:0] outa, outb, outc;
  logic       busy, done;

  logic [15:0] in16;
  logic        we16, ixinc16, save16;
  logic [2:0]  wa16, raa16;
  logic [15:0] outa16, outb16, outc16;
  logic        busy16, done16;

`ifdef REGFILE_CTX_DIRECT_OUT_EN
  logic [31:0]  allregs;
  logic [127:0] allregs16;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mdl [4];
  logic [7:0] sh  [4];
  logic [7:0] exp_q [$];

  regfile_ctx #(.WIDTH(8), .NREG(4)) dut8 (
    .CLK(clk), .RESET(rst), .IN(in8), .WE(we), .WA(wa), .RAA(raa), .RAB(rab),
    .CSEL(csel), .SWAP(swap), .IXINC(ixinc), .IXDEC(ixdec), .SAVE(save),
    .RESTORE(restore), .OUTA(outa), .OUTB(outb), .OUTC(outc), .BUSY(busy),
    .DONE(done)
`ifdef REGFILE_CTX_DIRECT_OUT_EN
    , .ALLREGS(allregs)
`endif
  );

  regfile_ctx #(.WIDTH(16), .NREG(8)) dut16 (
    .CLK(clk), .RESET(rst), .IN(in16), .WE(we16), .WA(wa16), .RAA(raa16),
    .RAB(3'd0), .CSEL(1'b1), .SWAP(1'b0), .IXINC(ixinc16), .IXDEC(1'b0),
    .SAVE(save16), .RESTORE(1'b0), .OUTA(outa16), .OUTB(outb16),
    .OUTC(outc16), .BUSY(busy16), .DONE(done16)
`ifdef REGFILE_CTX_DIRECT_OUT_EN
    , .ALLREGS(allregs16)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    we = 1'b1; wa = a; in8 = d;
    tick();
    we = 1'b0;
    mdl[a] = d;
  endtask

  // Pushes expected (OUTA, OUTB) pairs for read addresses (i, 3-i).
  task automatic push_regs();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(mdl[i]);
      exp_q.push_back(mdl[3-i]);
    end
  endtask

  task automatic test_reset();
    logic [7:0] ea, eb;
    tick();
    @(posedge clk); #3 rst = 1'b1; #4 rst = 1'b0;
    for (int i = 0; i < 4; i++) mdl[i] = 8'h00;
    push_regs();
    for (int i = 0; i < 4; i++) begin
      raa = 2'(i); rab = 2'(3-i); #1;
      ea = exp_q.pop_front(); eb = exp_q.pop_front();
      n_checks++;
      if (outa !== ea || outb !== eb) begin
        n_fail++; $display("FAIL reset_read r%0d: got %h/%h want %h/%h", i, outa, outb, ea, eb);
      end
    end
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: busy=%b done=%b want 0/0", busy, done);
    end
    csel = 1'b0; #1;
    n_checks++;
    if (outc !== 8'h00) begin n_fail++; $display("FAIL outc_zero: got %h want 00", outc); end
    csel = 1'b1; #1;
    n_checks++;
    if (outc !== 8'hFF) begin n_fail++; $display("FAIL outc_ones: got %h want ff", outc); end
    csel = 1'b0;
  endtask

  task automatic test_write_swap();
    logic [7:0] ea, eb, t;
    wr(2'd0, 8'h12); wr(2'd1, 8'h34); wr(2'd2, 8'h56); wr(2'd3, 8'h78);
    swap = 1'b1; raa = 2'd0; rab = 2'd1;
    tick();
    swap = 1'b0;
    t = mdl[0]; mdl[0] = mdl[1]; mdl[1] = t;
    exp_q.push_back(8'h34); exp_q.push_back(8'h12);
    #1;
    ea = exp_q.pop_front(); eb = exp_q.pop_front();
    n_checks++;
    if (outa !== ea || outb !== eb) begin
      n_fail++; $display("FAIL swap01: got %h/%h want %h/%h", outa, outb, ea, eb);
    end
    swap = 1'b1; raa = 2'd2; rab = 2'd2;
    tick();
    swap = 1'b0;
    swap = 1'b1; we = 1'b1; wa = 2'd2; in8 = 8'h99; raa = 2'd0; rab = 2'd1;
    tick();
    swap = 1'b0; we = 1'b0;
    t = mdl[0]; mdl[0] = mdl[1]; mdl[1] = t;
    push_regs();
    for (int i = 0; i < 4; i++) begin
      raa = 2'(i); rab = 2'(3-i); #1;
      ea = exp_q.pop_front(); eb = exp_q.pop_front();
      n_checks++;
      if (outa !== ea || outb !== eb) begin
        n_fail++; $display("FAIL swap_regs r%0d: got %h/%h want %h/%h", i, outa, outb, ea, eb);
      end
    end
  endtask

  task automatic test_ix();
    logic [7:0] ea;
    logic [7:0] want [5];
    logic       inc [5];
    logic       dec [5];
    logic       wen [5];
    want = '{8'h00, 8'hFF, 8'hFF, 8'h55, 8'h55};
    inc  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    dec  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    wen  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    wr(2'd3, 8'hFF);
    for (int k = 0; k < 5; k++) begin
      ixinc = inc[k]; ixdec = dec[k]; we = wen[k];
      wa = (k == 3) ? 2'd3 : 2'd0;
      in8 = (k == 3) ? 8'h55 : 8'h66;
      tick();
      ixinc = 1'b0; ixdec = 1'b0; we = 1'b0;
      if (k == 4) mdl[0] = 8'h66;
      mdl[3] = want[k];
      exp_q.push_back(mdl[3]);
      raa = 2'd3; rab = 2'd0; #1;
      ea = exp_q.pop_front();
      n_checks++;
      if (outa !== ea) begin n_fail++; $display("FAIL ix_step%0d: got %h want %h", k, outa, ea); end
    end
    n_checks++;
    if (outb !== mdl[0]) begin n_fail++; $display("FAIL ix_we_other: got %h want %h", outb, mdl[0]); end
  endtask

  // Waits for BUSY to drop, returning the number of sampled BUSY cycles.
  task automatic wait_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      n++;
      tick();
    end
  endtask

  task automatic test_save_restore();
    logic [7:0] ea, eb;
    int n;
    wr(2'd0, 8'h11); wr(2'd1, 8'h22); wr(2'd2, 8'h33); wr(2'd3, 8'h44);
    save = 1'b1; tick(); save = 1'b0;
    for (int i = 0; i < 4; i++) sh[i] = mdl[i];
    wait_busy(n);
    n_checks++;
    if (n != 4) begin n_fail++; $display("FAIL save_busy_len: got %0d want 4", n); end
    n_checks++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL save_done: got %b want 1", done); end
    tick();
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL save_done_pulse: got %b want 0", done); end
    for (int i = 0; i < 4; i++) wr(2'(i), 8'h00);
    restore = 1'b1; tick(); restore = 1'b0;
    wait_busy(n);
    n_checks++;
    if (n != 4 || done !== 1'b1) begin
      n_fail++; $display("FAIL restore_timing: len %0d done %b want 4/1", n, done);
    end
    for (int i = 0; i < 4; i++) mdl[i] = sh[i];
    push_regs();
    for (int i = 0; i < 4; i++) begin
      raa = 2'(i); rab = 2'(3-i); #1;
      ea = exp_q.pop_front(); eb = exp_q.pop_front();
      n_checks++;
      if (outa !== ea || outb !== eb) begin
        n_fail++; $display("FAIL restore_regs r%0d: got %h/%h want %h/%h", i, outa, outb, ea, eb);
      end
    end
  endtask

  task automatic test_ignore_busy();
    logic [7:0] ea, eb;
    int n;
    wr(2'd0, 8'hA1); wr(2'd1, 8'hA2); wr(2'd2, 8'hA3); wr(2'd3, 8'hA4);
    for (int i = 0; i < 4; i++) sh[i] = mdl[i];
    save = 1'b1; tick(); save = 1'b0;
    we = 1'b1; wa = 2'd0; in8 = 8'hAA; swap = 1'b1; raa = 2'd0; rab = 2'd1;
    restore = 1'b1; ixinc = 1'b1;
    wait_busy(n);
    we = 1'b0; swap = 1'b0; restore = 1'b0; ixinc = 1'b0;
    n_checks++;
    if (n != 4 || done !== 1'b1) begin
      n_fail++; $display("FAIL ignore_timing: len %0d done %b want 4/1", n, done);
    end
    tick();
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_no_second: busy %b want 0", busy); end
    push_regs();
    for (int i = 0; i < 4; i++) begin
      raa = 2'(i); rab = 2'(3-i); #1;
      ea = exp_q.pop_front(); eb = exp_q.pop_front();
      n_checks++;
      if (outa !== ea || outb !== eb) begin
        n_fail++; $display("FAIL ignore_regs r%0d: got %h/%h want %h/%h", i, outa, outb, ea, eb);
      end
    end
    for (int i = 0; i < 4; i++) wr(2'(i), 8'h00);
    restore = 1'b1; tick(); restore = 1'b0;
    wait_busy(n);
    for (int i = 0; i < 4; i++) mdl[i] = sh[i];
    push_regs();
    for (int i = 0; i < 4; i++) begin
      raa = 2'(i); rab = 2'(3-i); #1;
      ea = exp_q.pop_front(); eb = exp_q.pop_front();
      n_checks++;
      if (outa !== ea || outb !== eb) begin
        n_fail++; $display("FAIL ignore_shadow r%0d: got %h/%h want %h/%h", i, outa, outb, ea, eb);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    save = 1'b1; tick(); save = 1'b0;
    wait_busy(n);
    restore = 1'b1; tick(); restore = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL b2b_accept: busy %b done %b want 1/0", busy, done);
    end
    wait_busy(n);
    n_checks++;
    if (n != 4 || done !== 1'b1) begin
      n_fail++; $display("FAIL b2b_timing: len %0d done %b want 4/1", n, done);
    end
    tick();
  endtask

  task automatic test_abort();
    logic [7:0] ea, eb;
    int dones;
    for (int i = 0; i < 4; i++) wr(2'(i), 8'h00);
    restore = 1'b1; tick(); restore = 1'b0;
    tick();
    #2 rst = 1'b1; #4 rst = 1'b0;
    for (int i = 0; i < 4; i++) mdl[i] = 8'h00;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
    dones = 0;
    for (int k = 0; k < 6; k++) begin
      if (done !== 1'b0) dones++;
      tick();
    end
    n_checks++;
    if (dones != 0) begin n_fail++; $display("FAIL abort_done: %0d pulses want 0", dones); end
    push_regs();
    for (int i = 0; i < 4; i++) begin
      raa = 2'(i); rab = 2'(3-i); #1;
      ea = exp_q.pop_front(); eb = exp_q.pop_front();
      n_checks++;
      if (outa !== ea || outb !== eb) begin
        n_fail++; $display("FAIL abort_regs r%0d: got %h/%h want %h/%h", i, outa, outb, ea, eb);
      end
    end
`ifdef REGFILE_CTX_DIRECT_OUT_EN
    n_checks++;
    if (allregs !== 32'h0) begin n_fail++; $display("FAIL allregs: got %h want 0", allregs); end
`endif
  endtask

  task automatic test_wide();
    int n;
    we16 = 1'b1; wa16 = 3'd7; in16 = 16'hFFFF; tick(); we16 = 1'b0;
    raa16 = 3'd7; #1;
    n_checks++;
    if (outa16 !== 16'hFFFF) begin n_fail++; $display("FAIL wide_write: got %h want ffff", outa16); end
    ixinc16 = 1'b1; tick(); ixinc16 = 1'b0;
    n_checks++;
    if (outa16 !== 16'h0000) begin n_fail++; $display("FAIL wide_ix_wrap: got %h want 0000", outa16); end
    n_checks++;
    if (outc16 !== 16'hFFFF) begin n_fail++; $display("FAIL wide_outc: got %h want ffff", outc16); end
    save16 = 1'b1; tick(); save16 = 1'b0;
    n = 0;
    while (busy16 === 1'b1 && n < 30) begin n++; tick(); end
    n_checks++;
    if (n != 8 || done16 !== 1'b1) begin
      n_fail++; $display("FAIL wide_busy: len %0d done %b want 8/1", n, done16);
    end
  endtask

  initial begin
    rst = 1'b0; in8 = 8'h00; we = 1'b0; wa = 2'd0; raa = 2'd0; rab = 2'd0;
    csel = 1'b0; swap = 1'b0; ixinc = 1'b0; ixdec = 1'b0; save = 1'b0; restore = 1'b0;
    in16 = 16'h0000; we16 = 1'b0; wa16 = 3'd0; raa16 = 3'd0; ixinc16 = 1'b0; save16 = 1'b0;
    test_reset();
    test_write_swap();
    test_ix();
    test_save_restore();
    test_ignore_busy();
    test_back_to_back();
    test_abort();
    test_wide();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_ctx.md
Name: regfile_ctx

Overview:
- Parametrised successor to the CPU main register file: NREG general registers of WIDTH bits, with the last register acting as index register IX.
- Provides one write port, two combinational read ports, a constant-generator output, and a single-cycle register swap.
- Adds IX auto-increment/decrement and a shadow context bank, saved and restored by a multi-cycle sequencer (interrupt context switch).
- Sits between the control unit and the ALU/address path.

Parameters:
- WIDTH, 8, register width in bits (>=2)
- NREG, 4, number of live registers; power of two, >=2; register NREG-1 is IX
- AW, $clog2(NREG), address width (derived; not overridden)

Ports:
- CLK  input  1  system clock, rising edge
- RESET  input  1  asynchronous, active-high reset
- IN  input  WIDTH  write data
- WE  input  1  write enable for reg[WA]
- WA  input  AW  write address
- RAA  input  AW  read address, port A
- RAB  input  AW  read address, port B
- CSEL  input  1  constant select: 0 = all-zeros, 1 = all-ones
- SWAP  input  1  exchange reg[RAA] and reg[RAB]
- IXINC  input  1  IX <= IX+1
- IXDEC  input  1  IX <= IX-1
- SAVE  input  1  start copy of live bank into shadow bank
- RESTORE  input  1  start copy of shadow bank into live bank
- OUTA  output  WIDTH  reg[RAA], combinational
- OUTB  output  WIDTH  reg[RAB], combinational
- OUTC  output  WIDTH  constant: {WIDTH{CSEL}}
- BUSY  output  1  save/restore sequence in progress
- DONE  output  1  one-cycle pulse when a sequence completes

Behaviour:
- Reset (asynchronous, any state): all live and shadow registers 0, state IDLE, counter 0, BUSY=0, DONE=0. A reset mid-sequence aborts it with no DONE.
- OUTA, OUTB, OUTC are combinational and valid in every state, including BUSY.
- FSM states: IDLE, SAVING, RESTORING. BUSY=1 exactly when the state is not IDLE.
- IDLE priority per edge: SAVE > RESTORE > SWAP > WE > IXINC/IXDEC. Exactly one action per cycle; lower-priority requests that cycle are dropped.
  - SAVE: go to SAVING, CNT<=0; no register changes this edge.
  - RESTORE: go to RESTORING, CNT<=0.
  - SWAP: reg[RAA]<=reg[RAB] and reg[RAB]<=reg[RAA] on the same edge. RAA==RAB gives no change.
  - WE: reg[WA]<=IN. A write to IX overrides any IXINC/IXDEC that cycle.
  - IXINC xor IXDEC: IX modulo 2^WIDTH (0xFF+1 -> 0x00, 0x00-1 -> 0xFF for WIDTH=8). Both asserted: no change.
- SAVING, per edge: shadow[CNT]<=reg[CNT].
  - CNT==NREG-1: go to IDLE, DONE<=1. Otherwise CNT<=CNT+1.
- RESTORING: same sequence with reg[CNT]<=shadow[CNT].
- Timing: BUSY is high for exactly NREG cycles, starting the cycle after the request. DONE is high for the single cycle after BUSY falls. Back-to-back requests are accepted on that DONE cycle.
- While BUSY: WE, SWAP, IXINC, IXDEC, SAVE and RESTORE are ignored (no queuing). Live registers change only through RESTORING copies.
- DONE is 0 in every other cycle.

Optional Feature:
- Macro REGFILE_CTX_DIRECT_OUT_EN.
- Defined: extra output port ALLREGS, output, WIDTH*NREG, reg[i] on bits [i*WIDTH +: WIDTH], combinational. Used for debug and register display.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset then read: assert RESET mid-clock; all RAA/RAB reads = 0x00, BUSY=0, DONE=0; OUTC=0x00 with CSEL=0 and 0xFF with CSEL=1.
- Write/swap: write A=0x12, B=0x34; SWAP RAA=0 RAB=1 -> next cycle OUTA(0)=0x34, OUTB(1)=0x12. SWAP with RAA=RAB=2 leaves C unchanged. SWAP and WE in the same cycle: swap wins, write dropped.
- IX arithmetic: IX=0xFF, IXINC -> 0x00; IXDEC -> 0xFF; IXINC+IXDEC -> unchanged; IXINC+WE(WA=3, IN=0x55) -> 0x55.
- Save/restore: regs {0x11,0x22,0x33,0x44}, pulse SAVE -> BUSY high exactly 4 cycles, DONE 1 cycle after. Overwrite all regs with 0x00, pulse RESTORE -> after DONE regs = {0x11,0x22,0x33,0x44}.
- Ignore while busy: during SAVING assert WE (WA=0, IN=0xAA), SWAP and RESTORE -> no effect; shadow[0] = pre-save value; no second sequence starts.
- Abort: RESET asserted in cycle 2 of RESTORING -> all regs 0, BUSY=0, no DONE pulse. Rerun with WIDTH=16, NREG=8: BUSY lasts 8 cycles; IX (reg 7) wraps 0xFFFF -> 0x0000.
